// File: rtl/spi_flash_responder_if.sv
// SPI pins plus local memory read port of the flash responder.
// slave = responder side, master = initiator / memory side.
interface spi_flash_responder_if #(
  parameter int MEM_AW = 17
);
  logic              SPI_CSS;
  logic              SPI_CLK;
  logic              SPI_MOSI;
  logic              SPI_MISO;
  logic              SPI_MISO_OE;
  logic              o_mem_rd;
  logic [MEM_AW-1:0] o_mem_addr;
  logic [7:0]        i_mem_data;
  logic              o_busy;
  logic              o_byte_sent;
  logic              o_bad_cmd;

  modport slave (
    input  SPI_CSS, SPI_CLK, SPI_MOSI, i_mem_data,
    output SPI_MISO, SPI_MISO_OE, o_mem_rd, o_mem_addr, o_busy, o_byte_sent, o_bad_cmd
  );

  modport master (
    output SPI_CSS, SPI_CLK, SPI_MOSI, i_mem_data,
    input  SPI_MISO, SPI_MISO_OE, o_mem_rd, o_mem_addr, o_busy, o_byte_sent, o_bad_cmd
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator answering READ (0x03) / FAST_READ (0x0B) from a byte memory port.
// Optional JEDEC ID (0x9F) response when SPI_RESP_JEDEC_ID_EN is defined.
module spi_flash_responder #(
  parameter int MEM_AW    = 17,
  parameter int DUMMY_CYC = 8,
  parameter int SYNC_STG  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_flash_responder_if.slave  bus
);
  localparam int CW = 8;
  // Only the last MEM_AW address bits (and 8 opcode bits) of the stream are ever needed.
  localparam int RW = (MEM_AW > 8) ? MEM_AW - 1 : 7;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  state_t state, nxt;

  logic [SYNC_STG-1:0] css_sync, sck_sync, mosi_sync;
  logic                css_s, sck_s, mosi_s, css_d, sck_d;
  logic                css_rise, css_fall, sck_rise, sck_fall;
  logic [RW-1:0]       rx;
  logic [7:0]          opcode, tx_sr;
  logic [MEM_AW-1:0]   addr, addr_in, mem_addr_c;
  logic [CW-1:0]       bit_cnt;
  logic                miso, miso_oe, mem_pend, fast, jedec;
  logic [1:0]          jidx, jidx_nxt;
  logic                op_read, op_fast, op_jedec;
  logic                mem_rd_c, byte_sent_c, bad_cmd_c;

  assign css_s    = css_sync[SYNC_STG-1];
  assign sck_s    = sck_sync[SYNC_STG-1];
  assign mosi_s   = mosi_sync[SYNC_STG-1];
  assign css_rise = css_s & ~css_d;
  assign css_fall = ~css_s & css_d;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  assign opcode   = {rx[6:0], mosi_s};
  assign addr_in  = {rx[MEM_AW-2:0], mosi_s};
  assign op_read  = (opcode == 8'h03);
  assign op_fast  = (opcode == 8'h0B);
`ifdef SPI_RESP_JEDEC_ID_EN
  assign op_jedec = (opcode == 8'h9F);
`else
  assign op_jedec = 1'b0;
`endif
  assign jidx_nxt = (jidx == 2'd3) ? 2'd3 : jidx + 2'd1;

  function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'hEF;
      2'd1:    return 8'h40;
      2'd2:    return 8'h18;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (css_rise) nxt = IDLE;
    else begin
      case (state)
        IDLE:  if (css_fall) nxt = CMD;
        CMD:   if (sck_rise && bit_cnt == CW'(7)) begin
                 if (op_read || op_fast) nxt = ADDR;
                 else if (op_jedec)      nxt = DATA;
                 else                    nxt = IGNORE;
               end
        ADDR:  if (sck_rise && bit_cnt == CW'(23))
                 nxt = (fast && DUMMY_CYC != 0) ? DUMMY : DATA;
        DUMMY: if (sck_rise && bit_cnt == CW'(DUMMY_CYC - 1)) nxt = DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd_c    = 1'b0;
    mem_addr_c  = '0;
    byte_sent_c = 1'b0;
    bad_cmd_c   = 1'b0;
    if (!css_rise && sck_rise) begin
      case (state)
        CMD:  bad_cmd_c = (bit_cnt == CW'(7)) && !(op_read || op_fast || op_jedec);
        ADDR: if (bit_cnt == CW'(23)) begin
                mem_rd_c   = 1'b1;
                mem_addr_c = addr_in;
              end
        DATA: if (bit_cnt == CW'(7)) begin
                byte_sent_c = 1'b1;
                if (!jedec) begin
                  mem_rd_c   = 1'b1;
                  mem_addr_c = addr + MEM_AW'(1);
                end
              end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      css_sync  <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      css_d     <= 1'b1;
      sck_d     <= 1'b0;
      rx        <= '0;
      bit_cnt   <= '0;
      addr      <= '0;
      tx_sr     <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      mem_pend  <= 1'b0;
      fast      <= 1'b0;
      jedec     <= 1'b0;
      jidx      <= '0;
    end else begin
      css_sync  <= {css_sync[SYNC_STG-2:0], bus.SPI_CSS};
      sck_sync  <= {sck_sync[SYNC_STG-2:0], bus.SPI_CLK};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], bus.SPI_MOSI};
      css_d     <= css_s;
      sck_d     <= sck_s;
      mem_pend  <= mem_rd_c;
      if (css_rise) begin
        // Abort: partial byte and any in-flight read data are discarded.
        miso     <= 1'b0;
        miso_oe  <= 1'b0;
        mem_pend <= 1'b0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: if (css_fall) begin
                  bit_cnt <= '0;
                  rx      <= '0;
                  fast    <= 1'b0;
                  jedec   <= 1'b0;
                  jidx    <= '0;
                end
          CMD: if (sck_rise) begin
                 rx <= {rx[RW-2:0], mosi_s};
                 if (bit_cnt == CW'(7)) begin
                   bit_cnt <= '0;
                   fast    <= op_fast;
                   if (op_jedec) begin
                     jedec <= 1'b1;
                     tx_sr <= jedec_byte(2'd0);
                   end
                 end else bit_cnt <= bit_cnt + CW'(1);
               end
          ADDR: if (sck_rise) begin
                  rx <= {rx[RW-2:0], mosi_s};
                  if (bit_cnt == CW'(23)) begin
                    bit_cnt <= '0;
                    addr    <= addr_in;
                  end else bit_cnt <= bit_cnt + CW'(1);
                end
          DUMMY: if (sck_rise) begin
                   if (bit_cnt == CW'(DUMMY_CYC - 1)) bit_cnt <= '0;
                   else                               bit_cnt <= bit_cnt + CW'(1);
                 end
          DATA: begin
                  if (sck_fall) begin
                    miso    <= tx_sr[7];
                    miso_oe <= 1'b1;
                    tx_sr   <= {tx_sr[6:0], 1'b0};
                  end
                  if (sck_rise) begin
                    if (bit_cnt == CW'(7)) begin
                      bit_cnt <= '0;
                      if (jedec) begin
                        jidx  <= jidx_nxt;
                        tx_sr <= jedec_byte(jidx_nxt);
                      end else addr <= addr + MEM_AW'(1);
                    end else bit_cnt <= bit_cnt + CW'(1);
                  end
                end
          default: ;
        endcase
        // Memory data lands between the 8th rise and the next fall.
        if (mem_pend) tx_sr <= bus.i_mem_data;
      end
    end
  end

  assign bus.SPI_MISO    = miso;
  assign bus.SPI_MISO_OE = miso_oe;
  assign bus.o_mem_rd    = mem_rd_c;
  assign bus.o_mem_addr  = mem_addr_c;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_byte_sent = byte_sent_c;
  assign bus.o_bad_cmd   = bad_cmd_c;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master tasks plus a 1-clk-latency memory model.
module tb_spi_flash_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.MEM_AW(17)) bus();
  spi_flash_responder #(.MEM_AW(17), .DUMMY_CYC(8), .SYNC_STG(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cnt_rd = 0, cnt_bs = 0, cnt_bad = 0;
  logic [16:0] addr_log [0:63];
  logic [7:0]  mem_q = 8'h00;
  logic        oe_seen;
  logic [7:0]  rb;
  int rd0, bs0, bad0;

  assign bus.i_mem_data = mem_q;

  // Memory: mem[i] = i ^ 0xA5, data valid one clk after the strobe.
  always @(posedge clk) begin
    if (bus.o_mem_rd) begin
      mem_q <= bus.o_mem_addr[7:0] ^ 8'hA5;
      addr_log[cnt_rd[5:0]] <= bus.o_mem_addr;
      cnt_rd <= cnt_rd + 1;
    end
    if (bus.o_byte_sent) cnt_bs <= cnt_bs + 1;
    if (bus.o_bad_cmd)   cnt_bad <= cnt_bad + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode 0: MOSI set after a fall, MISO sampled just before the rise; half period 4 clk.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.SPI_MOSI = tx[7-i];
      tick(4);
      rx[7-i] = bus.SPI_MISO;
      oe_seen = oe_seen | bus.SPI_MISO_OE;
      bus.SPI_CLK = 1'b1;
      tick(4);
      bus.SPI_CLK = 1'b0;
    end
  endtask

  task automatic css_low();
    bus.SPI_CSS = 1'b0;
    tick(4);
  endtask

  task automatic css_high();
    tick(2);
    bus.SPI_CSS = 1'b1;
    tick(6);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    spi_xfer(op, 8, d);
    spi_xfer(a[23:16], 8, d);
    spi_xfer(a[15:8], 8, d);
    spi_xfer(a[7:0], 8, d);
  endtask

  initial begin
    bus.SPI_CSS = 1'b1; bus.SPI_CLK = 1'b0; bus.SPI_MOSI = 1'b0;
    // Reset held 5 clk while SPI pins toggle.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.SPI_CSS = i[0]; bus.SPI_CLK = ~i[0]; bus.SPI_MOSI = i[1];
    end
    chk("rst_miso", {31'd0, bus.SPI_MISO}, 0);
    chk("rst_oe",   {31'd0, bus.SPI_MISO_OE}, 0);
    chk("rst_busy", {31'd0, bus.o_busy}, 0);
    chk("rst_flags", {29'd0, bus.o_mem_rd, bus.o_byte_sent, bus.o_bad_cmd}, 0);
    chk("rst_rd_cnt", cnt_rd, 0);
    bus.SPI_CSS = 1'b1; bus.SPI_CLK = 1'b0; bus.SPI_MOSI = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(6);
    chk("post_rst_busy", {31'd0, bus.o_busy}, 0);

    // READ 0x03 @0x10, 4 bytes.
    rd0 = cnt_rd; bs0 = cnt_bs;
    css_low();
    chk("rd_busy", {31'd0, bus.o_busy}, 1);
    oe_seen = 1'b0;
    send_hdr(8'h03, 24'h000010);
    chk("rd_hdr_oe", {31'd0, oe_seen}, 0);
    spi_xfer(8'h00, 8, rb); chk("rd_b0", rb, 8'hB5);
    spi_xfer(8'h00, 8, rb); chk("rd_b1", rb, 8'hB4);
    spi_xfer(8'h00, 8, rb); chk("rd_b2", rb, 8'hB7);
    spi_xfer(8'h00, 8, rb); chk("rd_b3", rb, 8'hB6);
    chk("rd_oe_data", {31'd0, bus.SPI_MISO_OE}, 1);
    css_high();
    chk("rd_bs_cnt", cnt_bs - bs0, 4);
    chk("rd_rd_cnt", cnt_rd - rd0, 5);
    chk("rd_addr0", addr_log[rd0], 17'h10);
    chk("rd_addr3", addr_log[rd0+3], 17'h13);
    chk("rd_addr4", addr_log[rd0+4], 17'h14);
    chk("rd_end_busy", {31'd0, bus.o_busy}, 0);
    chk("rd_end_oe", {31'd0, bus.SPI_MISO_OE}, 0);

    // FAST_READ 0x0B @0x1FFFF with address wrap.
    rd0 = cnt_rd;
    css_low();
    send_hdr(8'h0B, 24'h01FFFF);
    oe_seen = 1'b0;
    spi_xfer(8'h00, 8, rb);
    chk("fr_dummy_oe", {31'd0, oe_seen}, 0);
    spi_xfer(8'h00, 8, rb); chk("fr_b0", rb, 8'h5A);
    spi_xfer(8'h00, 8, rb); chk("fr_b1", rb, 8'hA5);
    css_high();
    chk("fr_addr0", addr_log[rd0], 17'h1FFFF);
    chk("fr_addr1", addr_log[rd0+1], 17'h00000);

    // Unsupported opcode 0x55 then 16 SCK.
    rd0 = cnt_rd; bad0 = cnt_bad;
    css_low();
    oe_seen = 1'b0;
    spi_xfer(8'h55, 8, rb);
    spi_xfer(8'hFF, 8, rb);
    spi_xfer(8'hFF, 8, rb);
    chk("bad_busy", {31'd0, bus.o_busy}, 1);
    css_high();
    chk("bad_cnt", cnt_bad - bad0, 1);
    chk("bad_oe", {31'd0, oe_seen}, 0);
    chk("bad_rd", cnt_rd - rd0, 0);

    // Normal READ after the bad command.
    css_low();
    send_hdr(8'h03, 24'h000020);
    spi_xfer(8'h00, 8, rb); chk("rd2_b0", rb, 8'h85);
    css_high();

    // Abort after 3 bits of the 2nd data byte.
    bs0 = cnt_bs; rd0 = cnt_rd;
    css_low();
    send_hdr(8'h03, 24'h000030);
    spi_xfer(8'h00, 8, rb); chk("ab_b0", rb, 8'h95);
    spi_xfer(8'h00, 3, rb);
    bus.SPI_CSS = 1'b1;
    tick(3);
    chk("ab_busy", {31'd0, bus.o_busy}, 0);
    chk("ab_oe", {31'd0, bus.SPI_MISO_OE}, 0);
    chk("ab_miso", {31'd0, bus.SPI_MISO}, 0);
    tick(6);
    chk("ab_bs", cnt_bs - bs0, 1);
    chk("ab_rd", cnt_rd - rd0, 2);

    // JEDEC ID opcode.
    rd0 = cnt_rd; bad0 = cnt_bad;
    css_low();
    oe_seen = 1'b0;
    spi_xfer(8'h9F, 8, rb);
`ifdef SPI_RESP_JEDEC_ID_EN
    spi_xfer(8'h00, 8, rb); chk("jd_b0", rb, 8'hEF);
    spi_xfer(8'h00, 8, rb); chk("jd_b1", rb, 8'h40);
    spi_xfer(8'h00, 8, rb); chk("jd_b2", rb, 8'h18);
    spi_xfer(8'h00, 8, rb); chk("jd_b3", rb, 8'h00);
    css_high();
    chk("jd_bad", cnt_bad - bad0, 0);
`else
    spi_xfer(8'h00, 8, rb);
    spi_xfer(8'h00, 8, rb);
    spi_xfer(8'h00, 8, rb);
    spi_xfer(8'h00, 8, rb);
    css_high();
    chk("jd_bad", cnt_bad - bad0, 1);
    chk("jd_oe", {31'd0, oe_seen}, 0);
`endif
    chk("jd_rd", cnt_rd - rd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
